reg_bus_responder: RTL and testbench

Host-facing register-bus responder for the accelerator's 16-bit register map. It decodes host read/write commands, holds the read/write configuration registers, and returns read data. It latches clear-on-read interrupt flags and turns accesses to the memory data ports (0x0E/0x0F) into handshaked RAM transfers at the address held in RAM_ADDR. It sits between the host link (UART/SPI command decoder) and the convolution, dense and memory-load engines.

---
 rtl/reg_bus_responder.sv | 198 +++++++++++++++++++
 tb/tb_reg_bus_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_responder.sv
// Host register-bus responder: config/status/interrupt registers plus handshaked RAM data ports.
// Optional feature macro: REG_BUS_ADDR_AUTOINC_EN (RAM_ADDR post-increments after each RAM transfer).
module reg_bus_responder #(
  parameter int ADDR_W     = 4,
  parameter int RAM_ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [15:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [15:0]           rsp_rdata_o,
  output logic [15:0]           conv_cfg1_o,
  output logic [15:0]           conv_cfg2_o,
  output logic [15:0]           conv_cfg3_o,
  output logic [15:0]           conv_cfg4_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  input  logic                  conv_done_i,
  input  logic                  conv_running_i,
  input  logic [13:0]           conv_count_i,
  input  logic                  mem_load_evt_i,
  input  logic                  conv_evt_i,
  input  logic                  dense_evt_i,
  output logic                  irq_o,
  output logic                  mem_wr_valid_o,
  input  logic                  mem_wr_ready_i,
  output logic [15:0]           mem_wr_data_o,
  output logic                  mem_rd_req_o,
  input  logic                  mem_rd_valid_i,
  input  logic [15:0]           mem_rd_data_i
);

`ifdef REG_BUS_ADDR_AUTOINC_EN
  localparam bit AUTOINC_EN = 1'b1;
`else
  localparam bit AUTOINC_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MEM_WR = 2'd1;
  localparam logic [1:0] ST_MEM_RD = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_RAM_LO  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_RAM_HI  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CFG1    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CFG2    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CFG3    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_CFG4    = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_IRQ     = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_MEM_WR  = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] A_MEM_RD  = ADDR_W'(15);

  logic [1:0]            state_q, state_d;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]           cfg1_q, cfg1_d, cfg2_q, cfg2_d, cfg3_q, cfg3_d, cfg4_q, cfg4_d;
  logic [2:0]            irq_en_q, irq_en_d, irq_act_q, irq_act_d;
  logic [15:0]           rsp_rdata_q, rsp_rdata_d;
  logic [15:0]           mem_wr_data_q, mem_wr_data_d;
  logic [31:0]           ram_addr_ext;
  logic [15:0]           irq_reg;
  logic [15:0]           reg_rdata;
  logic                  accept;
  logic                  irq_clear;
  logic [2:0]            irq_evt;

  assign ram_addr_ext = 32'(ram_addr_q);
  assign irq_evt      = {mem_load_evt_i, conv_evt_i, dense_evt_i};
  // Enable/active pairs sit at bits 15/14 (mem load), 13/12 (conv), 11/10 (dense).
  assign irq_reg = {irq_en_q[2], irq_act_q[2], irq_en_q[1], irq_act_q[1],
                    irq_en_q[0], irq_act_q[0], 10'b0};
  assign accept  = cmd_valid_i && (state_q == ST_IDLE);

  always_comb begin
    reg_rdata = 16'h0000;
    case (cmd_addr_i)
      A_VERSION: reg_rdata = 16'h0001;
      A_RAM_LO:  reg_rdata = ram_addr_ext[15:0];
      A_RAM_HI:  reg_rdata = ram_addr_ext[31:16];
      A_CFG1:    reg_rdata = cfg1_q;
      A_CFG2:    reg_rdata = cfg2_q;
      A_CFG3:    reg_rdata = cfg3_q;
      A_CFG4:    reg_rdata = cfg4_q;
      A_STATUS:  reg_rdata = {conv_done_i, conv_running_i, conv_count_i};
      A_IRQ:     reg_rdata = irq_reg;
      default:   reg_rdata = 16'h0000;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ram_addr_d    = ram_addr_q;
    cfg1_d        = cfg1_q;
    cfg2_d        = cfg2_q;
    cfg3_d        = cfg3_q;
    cfg4_d        = cfg4_q;
    irq_en_d      = irq_en_q;
    rsp_rdata_d   = rsp_rdata_q;
    mem_wr_data_d = mem_wr_data_q;
    irq_clear     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_RESP;
          rsp_rdata_d = 16'h0000;
          if (cmd_write_i) begin
            case (cmd_addr_i)
              A_RAM_LO: ram_addr_d = RAM_ADDR_W'({ram_addr_ext[31:16], cmd_wdata_i});
              A_RAM_HI: ram_addr_d = RAM_ADDR_W'({cmd_wdata_i, ram_addr_ext[15:0]});
              A_CFG1:   cfg1_d = cmd_wdata_i;
              A_CFG2:   cfg2_d = cmd_wdata_i;
              A_CFG3:   cfg3_d = cmd_wdata_i;
              A_CFG4:   cfg4_d = cmd_wdata_i;
              A_IRQ:    irq_en_d = {cmd_wdata_i[15], cmd_wdata_i[13], cmd_wdata_i[11]};
              A_MEM_WR: begin
                mem_wr_data_d = cmd_wdata_i;
                state_d       = ST_MEM_WR;
              end
              default: ;
            endcase
          end else if (cmd_addr_i == A_MEM_RD) begin
            state_d = ST_MEM_RD;
          end else begin
            rsp_rdata_d = reg_rdata;
            irq_clear   = (cmd_addr_i == A_IRQ);
          end
        end
      end
      ST_MEM_WR: begin
        if (mem_wr_ready_i) begin
          state_d     = ST_RESP;
          rsp_rdata_d = 16'h0000;
          if (AUTOINC_EN) ram_addr_d = ram_addr_q + RAM_ADDR_W'(1);
        end
      end
      ST_MEM_RD: begin
        if (mem_rd_valid_i) begin
          state_d     = ST_RESP;
          rsp_rdata_d = mem_rd_data_i;
          if (AUTOINC_EN) ram_addr_d = ram_addr_q + RAM_ADDR_W'(1);
        end
      end
      default: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
    endcase

    // A same-cycle event wins over the read-clear so no interrupt is lost.
    irq_act_d = (irq_act_q & ~{3{irq_clear}}) | (irq_evt & irq_en_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      ram_addr_q    <= '0;
      cfg1_q        <= 16'h0401;
      cfg2_q        <= 16'h0000;
      cfg3_q        <= 16'h0000;
      cfg4_q        <= 16'h0000;
      irq_en_q      <= 3'b000;
      irq_act_q     <= 3'b000;
      rsp_rdata_q   <= 16'h0000;
      mem_wr_data_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      ram_addr_q    <= ram_addr_d;
      cfg1_q        <= cfg1_d;
      cfg2_q        <= cfg2_d;
      cfg3_q        <= cfg3_d;
      cfg4_q        <= cfg4_d;
      irq_en_q      <= irq_en_d;
      irq_act_q     <= irq_act_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign rsp_rdata_o    = rsp_rdata_q;
  assign conv_cfg1_o    = cfg1_q;
  assign conv_cfg2_o    = cfg2_q;
  assign conv_cfg3_o    = cfg3_q;
  assign conv_cfg4_o    = cfg4_q;
  assign ram_addr_o     = ram_addr_q;
  assign irq_o          = |irq_act_q;
  assign mem_wr_valid_o = (state_q == ST_MEM_WR);
  assign mem_wr_data_o  = mem_wr_data_q;
  assign mem_rd_req_o   = (state_q == ST_MEM_RD);

endmodule

// File: tb/tb_reg_bus_responder.sv
// Directed bench for reg_bus_responder: register map, interrupts, RAM handshakes and mid-transfer reset.
// Expected RAM addresses follow REG_BUS_ADDR_AUTOINC_EN when it is defined.
module tb_reg_bus_responder;

`ifdef REG_BUS_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [3:0]  cmd_addr_i = 4'h0;
  logic [15:0] cmd_wdata_i = 16'h0000;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rsp_rdata_o;
  logic [15:0] conv_cfg1_o, conv_cfg2_o, conv_cfg3_o, conv_cfg4_o;
  logic [31:0] ram_addr_o;
  logic        conv_done_i = 1'b0;
  logic        conv_running_i = 1'b0;
  logic [13:0] conv_count_i = 14'h0;
  logic        mem_load_evt_i = 1'b0;
  logic        conv_evt_i = 1'b0;
  logic        dense_evt_i = 1'b0;
  logic        irq_o;
  logic        mem_wr_valid_o;
  logic        mem_wr_ready_i = 1'b0;
  logic [15:0] mem_wr_data_o;
  logic        mem_rd_req_o;
  logic        mem_rd_valid_i = 1'b0;
  logic [15:0] mem_rd_data_i = 16'h0000;

  int checks = 0;
  int errors = 0;

  int          wrDelay = 0;
  int          wrCnt = 0;
  int          wrBeats = 0;
  logic [15:0] wrSeen = 16'h0000;
  int          rdDelay = 0;
  int          rdCnt = 0;
  logic [15:0] rdValue = 16'h0000;
  logic [15:0] cfg1Snap = 16'h0000;

  always #5 clk_i = ~clk_i;

  reg_bus_responder #(.ADDR_W(4), .RAM_ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .conv_cfg1_o(conv_cfg1_o), .conv_cfg2_o(conv_cfg2_o), .conv_cfg3_o(conv_cfg3_o),
    .conv_cfg4_o(conv_cfg4_o), .ram_addr_o(ram_addr_o),
    .conv_done_i(conv_done_i), .conv_running_i(conv_running_i), .conv_count_i(conv_count_i),
    .mem_load_evt_i(mem_load_evt_i), .conv_evt_i(conv_evt_i), .dense_evt_i(dense_evt_i),
    .irq_o(irq_o),
    .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_ready_i(mem_wr_ready_i), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i)
  );

  // RAM model: answers after a programmable number of wait cycles, drives on the falling edge.
  always @(negedge clk_i) begin
    if (mem_wr_valid_o) begin
      wrSeen = mem_wr_data_o;
      wrBeats++;
      if (wrCnt >= wrDelay) mem_wr_ready_i = 1'b1;
      else begin
        wrCnt++;
        mem_wr_ready_i = 1'b0;
      end
    end else begin
      mem_wr_ready_i = 1'b0;
      wrCnt = 0;
    end
    if (mem_rd_req_o) begin
      if (rdCnt >= rdDelay) begin
        mem_rd_valid_i = 1'b1;
        mem_rd_data_i  = rdValue;
      end else begin
        rdCnt++;
        mem_rd_valid_i = 1'b0;
        mem_rd_data_i  = 16'h0000;
      end
    end else begin
      mem_rd_valid_i = 1'b0;
      mem_rd_data_i  = 16'h0000;
      rdCnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One host command: issue, wait (bounded) for the response, optionally stall rsp_ready, complete.
  task automatic applyStimulus(input bit isWrite, input logic [3:0] addr, input logic [15:0] wdata,
                               input int holdCycles, input logic [2:0] evt,
                               output logic [15:0] rdata, output int latency);
    @(negedge clk_i);
    checkOutput("cmdReadyIdle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = isWrite;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    {mem_load_evt_i, conv_evt_i, dense_evt_i} = evt;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    {mem_load_evt_i, conv_evt_i, dense_evt_i} = 3'b000;
    cfg1Snap = conv_cfg1_o;
    latency = 1;
    rdata = 16'h0000;
    while (!rsp_valid_o && latency < 100) begin
      @(negedge clk_i);
      latency++;
    end
    if (!rsp_valid_o) begin
      checkOutput("rspTimeout", 32'(rsp_valid_o), 32'd1);
      return;
    end
    rdata = rsp_rdata_o;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk_i);
      checkOutput("rspHoldData", 32'(rsp_rdata_o), 32'(rdata));
      checkOutput("rspHoldValid", 32'(rsp_valid_o), 32'd1);
      checkOutput("cmdReadyBusy", 32'(cmd_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checkOutput("rspDropped", 32'(rsp_valid_o), 32'd0);
  endtask

  task automatic regWrite(input logic [3:0] addr, input logic [15:0] wdata);
    logic [15:0] rd;
    int lat;
    applyStimulus(1'b1, addr, wdata, 0, 3'b000, rd, lat);
    checkOutput("wrRspZero", 32'(rd), 32'h0);
  endtask

  task automatic regRead(input string tag, input logic [3:0] addr, input logic [15:0] expected);
    logic [15:0] rd;
    int lat;
    applyStimulus(1'b0, addr, 16'h0000, 0, 3'b000, rd, lat);
    checkOutput(tag, 32'(rd), 32'(expected));
    checkOutput({tag, "Lat"}, 32'(lat), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    int lat;
    int beats0;

    repeat (3) @(negedge clk_i);
    checkOutput("rstCmdReady", 32'(cmd_ready_o), 32'd1);
    checkOutput("rstRspValid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rstMemWrValid", 32'(mem_wr_valid_o), 32'd0);
    checkOutput("rstMemRdReq", 32'(mem_rd_req_o), 32'd0);
    checkOutput("rstIrq", 32'(irq_o), 32'd0);
    checkOutput("rstCfg1", 32'(conv_cfg1_o), 32'h0401);
    checkOutput("rstRamAddr", ram_addr_o, 32'h0);
    rst_ni = 1'b1;

    regRead("rdVersion", 4'h0, 16'h0001);
    regRead("rdCfg1Rst", 4'h3, 16'h0401);
    regRead("rdCfg4Rst", 4'h6, 16'h0000);

    regWrite(4'h3, 16'hA5A5);
    checkOutput("cfg1AtN1", 32'(cfg1Snap), 32'h0000A5A5);
    regRead("rdCfg1", 4'h3, 16'hA5A5);
    regWrite(4'h4, 16'h1111);
    regWrite(4'h5, 16'h2222);
    regWrite(4'h6, 16'h3333);
    checkOutput("cfg2Out", 32'(conv_cfg2_o), 32'h1111);
    checkOutput("cfg3Out", 32'(conv_cfg3_o), 32'h2222);
    checkOutput("cfg4Out", 32'(conv_cfg4_o), 32'h3333);

    conv_done_i = 1'b1; conv_running_i = 1'b0; conv_count_i = 14'h1234;
    regWrite(4'h7, 16'hFFFF);
    regRead("rdStatusA", 4'h7, 16'h9234);
    conv_done_i = 1'b0; conv_running_i = 1'b1; conv_count_i = 14'h3FFF;
    regRead("rdStatusB", 4'h7, 16'h7FFF);
    regWrite(4'hA, 16'hBEEF);
    regRead("rdUnmapped", 4'hA, 16'h0000);
    regWrite(4'h0, 16'h5555);
    regRead("rdVersionRO", 4'h0, 16'h0001);

    regWrite(4'h8, 16'hFFFF);
    checkOutput("irqIdle", 32'(irq_o), 32'd0);
    conv_evt_i = 1'b1;
    @(negedge clk_i);
    conv_evt_i = 1'b0;
    checkOutput("irqSet", 32'(irq_o), 32'd1);
    regRead("irqRead1", 4'h8, 16'hB800);
    checkOutput("irqCleared", 32'(irq_o), 32'd0);
    regRead("irqRead2", 4'h8, 16'hA800);
    applyStimulus(1'b0, 4'h8, 16'h0000, 0, 3'b001, rd, lat);
    checkOutput("irqReadCoinc", 32'(rd), 32'hA800);
    checkOutput("irqCoincKept", 32'(irq_o), 32'd1);
    regRead("irqReadDense", 4'h8, 16'hAC00);
    checkOutput("irqDenseCleared", 32'(irq_o), 32'd0);
    regWrite(4'h8, 16'h8000);
    mem_load_evt_i = 1'b1; dense_evt_i = 1'b1;
    @(negedge clk_i);
    mem_load_evt_i = 1'b0; dense_evt_i = 1'b0;
    checkOutput("irqMemLoad", 32'(irq_o), 32'd1);
    regRead("irqReadMemLoad", 4'h8, 16'hC000);
    regWrite(4'h8, 16'h0000);
    conv_evt_i = 1'b1;
    @(negedge clk_i);
    conv_evt_i = 1'b0;
    checkOutput("irqDisabled", 32'(irq_o), 32'd0);

    regWrite(4'h1, 16'hFFFF);
    regWrite(4'h2, 16'h0000);
    checkOutput("ramAddrSet", ram_addr_o, 32'h0000FFFF);
    regRead("rdRamLo", 4'h1, 16'hFFFF);
    wrDelay = 3;
    beats0 = wrBeats;
    applyStimulus(1'b1, 4'hE, 16'h1234, 0, 3'b000, rd, lat);
    checkOutput("memWrData", 32'(wrSeen), 32'h1234);
    checkOutput("memWrBeats", 32'(wrBeats - beats0), 32'd4);
    checkOutput("memWrLat", 32'(lat), 32'd5);
    checkOutput("memWrRsp", 32'(rd), 32'h0);
    checkOutput("memWrAddr", ram_addr_o, AUTOINC ? 32'h00010000 : 32'h0000FFFF);
    regRead("rdRamHi", 4'h2, AUTOINC ? 16'h0001 : 16'h0000);

    regWrite(4'h1, 16'hFFFF);
    regWrite(4'h2, 16'hFFFF);
    wrDelay = 0;
    applyStimulus(1'b1, 4'hE, 16'h5555, 0, 3'b000, rd, lat);
    checkOutput("memWrZeroLat", 32'(lat), 32'd2);
    checkOutput("memWrWrap", ram_addr_o, AUTOINC ? 32'h00000000 : 32'hFFFFFFFF);

    rdDelay = 2;
    rdValue = 16'hBEEF;
    applyStimulus(1'b0, 4'hF, 16'h0000, 4, 3'b000, rd, lat);
    checkOutput("memRdData", 32'(rd), 32'hBEEF);
    checkOutput("memRdLat", 32'(lat), 32'd4);
    checkOutput("memRdAddr", ram_addr_o, AUTOINC ? 32'h00000001 : 32'hFFFFFFFF);
    rdDelay = 0;
    rdValue = 16'h0F0F;
    applyStimulus(1'b0, 4'hF, 16'h0000, 0, 3'b000, rd, lat);
    checkOutput("memRdZeroData", 32'(rd), 32'h0F0F);
    checkOutput("memRdZeroLat", 32'(lat), 32'd2);
    checkOutput("memRdZeroAddr", ram_addr_o, AUTOINC ? 32'h00000002 : 32'hFFFFFFFF);

    wrDelay = 1000;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 4'hE; cmd_wdata_i = 16'h7777;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checkOutput("abortWrValid", 32'(mem_wr_valid_o), 32'd1);
    checkOutput("abortBusy", 32'(cmd_ready_o), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("abortWrDrop", 32'(mem_wr_valid_o), 32'd0);
    checkOutput("abortCmdReady", 32'(cmd_ready_o), 32'd1);
    checkOutput("abortCfg1", 32'(conv_cfg1_o), 32'h0401);
    checkOutput("abortRamAddr", ram_addr_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wrDelay = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("abortNoRsp", 32'(rsp_valid_o), 32'd0);
    end
    regRead("rdCfg1AfterRst", 4'h3, 16'h0401);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
